// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider width, iteration counter width and FSM encoding.
package cpu_defs;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring divide iteration: shift in the next dividend bit and subtract
// the divisor when it fits, producing one quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;

  // The remainder never exceeds the divisor, so when the subtract succeeds the
  // difference fits in WIDTH bits and modular subtraction yields it directly.
  always_comb begin
    partial   = {rem_in, dividend_bit};
    no_borrow = (partial >= {1'b0, divisor});
    diff      = partial[WIDTH-1:0] - divisor;
    rem_out   = no_borrow ? diff : partial[WIDTH-1:0];
    quo_bit   = no_borrow;
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative MIPS DIV/DIVU unit for the EX stage: one quotient bit per cycle,
// stalls the pipeline while busy and hands off results only when EX advances.
module div_iter_unit
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_opE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] src_aE,
  input  logic [WIDTH-1:0] src_bE,
  input  logic             killE,
  input  logic             longest_stall,
  output logic             alu_stallE,
  output logic             div_validE,
  output logic [WIDTH-1:0] quotientE,
  output logic [WIDTH-1:0] remainderE
);

  div_state_t state, state_next;

  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg;
  logic             r_neg;

  logic             start;
  logic             last;
  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fin;

  always_comb begin
    start    = (state == DIV_IDLE) && div_opE && !killE;
    last     = (state == DIV_BUSY) && (counter == CNT_W'(WIDTH - 1));
    div_zero = (src_bE == '0);
    a_mag    = (div_signedE && src_aE[WIDTH-1]) ? -src_aE : src_aE;
    b_mag    = (div_signedE && src_bE[WIDTH-1]) ? -src_bE : src_bE;
    q_fin    = {a_q[WIDTH-2:0], step_q};
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem_q),
    .divisor     (b_q),
    .dividend_bit(a_q[WIDTH-1]),
    .rem_out     (step_rem),
    .quo_bit     (step_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Kill outranks both completion and a new start in every state.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: begin
        if (start) begin
          state_next = div_zero ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (killE) begin
          state_next = DIV_IDLE;
        end else if (last) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (killE || !longest_stall) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  // The dividend register doubles as the quotient shift register: each step
  // consumes its MSB and appends the new quotient bit at the LSB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      quotientE  <= '0;
      remainderE <= '0;
    end else if (start) begin
      if (div_zero) begin
        quotientE  <= '1;
        remainderE <= src_aE;
      end else begin
        a_q     <= a_mag;
        b_q     <= b_mag;
        rem_q   <= '0;
        counter <= '0;
        q_neg   <= div_signedE && (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
        r_neg   <= div_signedE && src_aE[WIDTH-1];
      end
    end else if ((state == DIV_BUSY) && !killE) begin
      a_q     <= q_fin;
      rem_q   <= step_rem;
      counter <= counter + CNT_W'(1);
      if (last) begin
        quotientE  <= q_neg ? -q_fin : q_fin;
        remainderE <= r_neg ? -step_rem : step_rem;
      end
    end
  end

  // Stall deliberately ignores longest_stall to avoid a loop through the hazard unit.
  always_comb begin
    alu_stallE = div_opE && (state != DIV_DONE) && !killE;
    div_validE = (state == DIV_DONE);
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: scoreboarded divides, latency,
// kill, cache-stall hold, divide-by-zero, signed overflow and async reset.
module tb_div_iter_unit;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        div_opE;
  logic        div_signedE;
  logic [31:0] src_aE;
  logic [31:0] src_bE;
  logic        killE;
  logic        longest_stall;
  logic        alu_stallE;
  logic        div_validE;
  logic [31:0] quotientE;
  logic [31:0] remainderE;

  int   tests;
  int   failed;
  exp_t sb[$];

  div_iter_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_opE      (div_opE),
    .div_signedE  (div_signedE),
    .src_aE       (src_aE),
    .src_bE       (src_bE),
    .killE        (killE),
    .longest_stall(longest_stall),
    .alu_stallE   (alu_stallE),
    .div_validE   (div_validE),
    .quotientE    (quotientE),
    .remainderE   (remainderE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t        e;
    logic [31:0] ma, mb, uq, ur;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else begin
      ma  = (sgn && a[31]) ? (32'd0 - a) : a;
      mb  = (sgn && b[31]) ? (32'd0 - b) : b;
      uq  = ma / mb;
      ur  = ma % mb;
      e.q = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
      e.r = (sgn && a[31]) ? (32'd0 - ur) : ur;
    end
    return e;
  endfunction

  // Starts at a negedge; returns at negedge+1 of the first DONE cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string tag, output int stalls);
    exp_t e;
    int   guard;
    sb.push_back(model(a, b, sgn));
    src_aE      = a;
    src_bE      = b;
    div_signedE = sgn;
    div_opE     = 1'b1;
    stalls      = 0;
    guard       = 0;
    #1;
    while (!div_validE && guard < 100) begin
      if (alu_stallE) stalls++;
      @(negedge clk);
      #1;
      guard++;
    end
    e = sb.pop_front();
    tests++;
    if (div_validE !== 1'b1) begin
      $display("FAIL %s timeout: div_validE=%b after %0d cycles, required 1", tag, div_validE, guard);
      failed++;
    end else begin
      tests++;
      if (quotientE !== e.q) begin
        $display("FAIL %s quotient: got %h required %h", tag, quotientE, e.q);
        failed++;
      end
      tests++;
      if (remainderE !== e.r) begin
        $display("FAIL %s remainder: got %h required %h", tag, remainderE, e.r);
        failed++;
      end
    end
  endtask

  // EX advances with a non-divide instruction; the unit must be back in IDLE.
  task automatic finish_div(input string tag);
    div_opE = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (div_validE !== 1'b0 || alu_stallE !== 1'b0) begin
      $display("FAIL %s idle_after: valid=%b stall=%b required 0/0", tag, div_validE, alu_stallE);
      failed++;
    end
  endtask

  task automatic check_stalls(input string tag, input int got, input int req);
    tests++;
    if (got !== req) begin
      $display("FAIL %s stall_cycles: got %0d required %0d", tag, got, req);
      failed++;
    end
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    div_opE       = 1'b0;
    div_signedE   = 1'b0;
    src_aE        = '0;
    src_bE        = '0;
    killE         = 1'b0;
    longest_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if ({alu_stallE, div_validE, quotientE, remainderE} !== 66'd0) begin
      $display("FAIL reset_state: stall=%b valid=%b q=%h r=%h required all 0",
               alu_stallE, div_validE, quotientE, remainderE);
      failed++;
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (div_validE !== 1'b0 || alu_stallE !== 1'b0) begin
      $display("FAIL idle_no_op: valid=%b stall=%b required 0/0", div_validE, alu_stallE);
      failed++;
    end
  endtask

  task automatic test_divu_basic();
    int st;
    @(negedge clk);
    run_div(32'd100, 32'd7, 1'b0, "divu_100_7", st);
    check_stalls("divu_100_7", st, 33);
    tests++;
    if (alu_stallE !== 1'b0) begin
      $display("FAIL done_stall_low: got %b required 0", alu_stallE);
      failed++;
    end
    finish_div("divu_100_7");
  endtask

  task automatic test_signed();
    int st;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2", st);
    tests++;
    if (quotientE !== 32'hFFFF_FFFD || remainderE !== 32'hFFFF_FFFF) begin
      $display("FAIL div_m7_2 const: got q=%h r=%h required FFFFFFFD/FFFFFFFF", quotientE, remainderE);
      failed++;
    end
    finish_div("div_m7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf", st);
    tests++;
    if (quotientE !== 32'h8000_0000 || remainderE !== 32'd0) begin
      $display("FAIL div_ovf const: got q=%h r=%h required 80000000/00000000", quotientE, remainderE);
      failed++;
    end
    check_stalls("div_ovf", st, 33);
    finish_div("div_ovf");
  endtask

  task automatic test_div_zero();
    int st;
    run_div(32'd5, 32'd0, 1'b0, "divu_5_0", st);
    check_stalls("divu_5_0", st, 1);
    tests++;
    if (quotientE !== 32'hFFFF_FFFF || remainderE !== 32'd5) begin
      $display("FAIL divu_5_0 const: got q=%h r=%h required FFFFFFFF/00000005", quotientE, remainderE);
      failed++;
    end
    finish_div("divu_5_0");
  endtask

  task automatic test_kill();
    int st;
    int seen;
    src_aE      = 32'd1000;
    src_bE      = 32'd3;
    div_signedE = 1'b0;
    div_opE     = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    killE = 1'b1;
    #1;
    tests++;
    if (alu_stallE !== 1'b0) begin
      $display("FAIL kill_stall: got %b required 0", alu_stallE);
      failed++;
    end
    @(negedge clk);
    killE   = 1'b0;
    div_opE = 1'b0;
    seen    = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (div_validE) seen++;
      @(negedge clk);
    end
    tests++;
    if (seen !== 0) begin
      $display("FAIL kill_no_valid: div_validE high %0d cycles, required 0", seen);
      failed++;
    end
    run_div(32'd9, 32'd3, 1'b0, "divu_9_3", st);
    tests++;
    if (quotientE !== 32'd3 || remainderE !== 32'd0) begin
      $display("FAIL divu_9_3 const: got q=%h r=%h required 3/0", quotientE, remainderE);
      failed++;
    end
    finish_div("divu_9_3");
  endtask

  task automatic test_cache_stall();
    int st;
    longest_stall = 1'b1;
    run_div(32'd1000, 32'd7, 1'b0, "divu_stall", st);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (div_validE !== 1'b1 || alu_stallE !== 1'b0 ||
          quotientE !== 32'd142 || remainderE !== 32'd6) begin
        $display("FAIL hold_cycle%0d: valid=%b stall=%b q=%h r=%h required 1/0/0000008e/00000006",
                 i, div_validE, alu_stallE, quotientE, remainderE);
        failed++;
      end
      if (i < 4) begin
        @(negedge clk);
        #1;
      end
    end
    longest_stall = 1'b0;
    finish_div("divu_stall");
  endtask

  task automatic test_reset_mid();
    src_aE      = 32'd50000;
    src_bE      = 32'd13;
    div_signedE = 1'b0;
    div_opE     = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    resetn  = 1'b0;
    div_opE = 1'b0;
    #1;
    tests++;
    if ({alu_stallE, div_validE, quotientE, remainderE} !== 66'd0) begin
      $display("FAIL reset_mid: stall=%b valid=%b q=%h r=%h required all 0",
               alu_stallE, div_validE, quotientE, remainderE);
      failed++;
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    begin
      int st;
      run_div(32'd1, 32'd1, 1'b0, "divu_1_1", st);
      check_stalls("divu_1_1", st, 33);
    end
    finish_div("divu_1_1");
  endtask

  task automatic test_back_to_back();
    int          st;
    logic [31:0] a, b;
    logic        sgn;
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      sgn = 1'($urandom_range(0, 1));
      if (i == 3) b = 32'd0;
      if (i == 5) b = 32'hFFFF_FFFF;
      run_div(a, b, sgn, "b2b", st);
      check_stalls("b2b", st, (b == 32'd0) ? 1 : 33);
      finish_div("b2b");
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_kill();
    test_cache_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
